// File: rtl/jtkiwi_objlb_if.sv
// Draw/display/mixer signal bundle of the Kiwi object line buffer.
interface jtkiwi_objlb_if #(
  parameter int AW = 9,
  parameter int DW = 9
);
  logic          pxl_cen;
  logic          hs;
  logic          flip;
  logic [8:0]    hdump;
  logic          buf_we;
  logic [AW-1:0] buf_addr;
  logic [DW-1:0] buf_data;
  logic [DW-1:0] obj_pxl;
  logic          clr_busy;

  modport master (
    output pxl_cen, hs, flip, hdump, buf_we, buf_addr, buf_data,
    input  obj_pxl, clr_busy
  );

  modport slave (
    input  pxl_cen, hs, flip, hdump, buf_we, buf_addr, buf_data,
    output obj_pxl, clr_busy
  );
endinterface

// File: rtl/jtkiwi_objlb.sv
// Double-buffered object line buffer: one bank is drawn while the other is
// scanned at pixel rate and erased behind the read.
module jtkiwi_objlb #(
  parameter int            AW   = 9,
  parameter int            DW   = 9,
  parameter logic [AW-1:0] HMAX = 9'd383
) (
  input  logic           clk,
  input  logic           rst,
  jtkiwi_objlb_if.slave  bus
);
  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

  state_t        r_state, w_state_nxt;
  logic [AW-1:0] r_cc;
  logic          r_sel;
  logic          r_hs_l;
  logic          r_swap_p0;
  logic          r_vld_p0;
  logic [AW-1:0] r_ea_p0;
  logic          r_ebank_p0;
  logic [DW-1:0] r_obj_pxl;

  logic [DW-1:0] r_mem_a [0:(1<<AW)-1];
  logic [DW-1:0] r_mem_b [0:(1<<AW)-1];

  logic          w_run;
  logic          w_draw;
  logic          w_hs_rise;
  logic [AW-1:0] w_ra;
  logic [DW-1:0] w_rd_p0;
  logic          w_we_a, w_we_b;
  logic [AW-1:0] w_addr_a, w_addr_b;
  logic [DW-1:0] w_din_a, w_din_b;

  assign w_run     = (r_state == RUN);
  assign w_hs_rise = bus.hs & ~r_hs_l;
  assign w_ra      = bus.flip ? {bus.hdump[8], ~bus.hdump[7:0]} : bus.hdump;
  assign w_draw    = w_run & bus.buf_we & (|bus.buf_data[3:0]) & (bus.buf_addr <= HMAX);
  assign w_rd_p0   = r_ebank_p0 ? r_mem_b[r_ea_p0] : r_mem_a[r_ea_p0];

  assign bus.obj_pxl  = r_obj_pxl;
  assign bus.clr_busy = ~w_run;

  always_ff @(posedge clk) begin
    if (rst) r_state <= CLEAR;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      CLEAR:   if (r_cc == '1) w_state_nxt = RUN;
      RUN:     w_state_nxt = RUN;
      default: w_state_nxt = CLEAR;
    endcase
  end

  // p0: capture read/erase address and the display bank it belongs to
  always_ff @(posedge clk) begin
    if (w_run && bus.pxl_cen) begin
      r_ea_p0    <= w_ra;
      r_ebank_p0 <= ~r_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cc      <= '0;
      r_sel     <= 1'b0;
      r_hs_l    <= 1'b0;
      r_swap_p0 <= 1'b0;
      r_vld_p0  <= 1'b0;
      r_obj_pxl <= '0;
    end else begin
      r_hs_l    <= bus.hs;
      r_swap_p0 <= w_run & w_hs_rise;
      r_vld_p0  <= w_run & bus.pxl_cen;
      if (!w_run)    r_cc  <= r_cc + 1'b1;
      if (r_swap_p0) r_sel <= ~r_sel;
      // p1: pixel out, the same location is erased below
      if (r_vld_p0)  r_obj_pxl <= w_rd_p0;
    end
  end

  // Single write port per bank; a fresh draw beats a stale erase right after a swap
  always_comb begin
    w_we_a   = 1'b0;
    w_we_b   = 1'b0;
    w_addr_a = r_cc;
    w_addr_b = r_cc;
    w_din_a  = '0;
    w_din_b  = '0;
    if (!w_run) begin
      w_we_a = 1'b1;
      w_we_b = 1'b1;
    end else begin
      if (r_vld_p0 && !r_ebank_p0) begin
        w_we_a   = 1'b1;
        w_addr_a = r_ea_p0;
      end
      if (r_vld_p0 && r_ebank_p0) begin
        w_we_b   = 1'b1;
        w_addr_b = r_ea_p0;
      end
      if (w_draw && !r_sel) begin
        w_we_a   = 1'b1;
        w_addr_a = bus.buf_addr;
        w_din_a  = bus.buf_data;
      end
      if (w_draw && r_sel) begin
        w_we_b   = 1'b1;
        w_addr_b = bus.buf_addr;
        w_din_b  = bus.buf_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_we_a) r_mem_a[w_addr_a] <= w_din_a;
    if (w_we_b) r_mem_b[w_addr_b] <= w_din_b;
  end
endmodule

// File: tb/tb_jtkiwi_objlb.sv
// Bench for jtkiwi_objlb: directed and random draw/swap/scan against a two-bank line model.
module tb_jtkiwi_objlb;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  jtkiwi_objlb_if bus ();
  jtkiwi_objlb dut (.clk(clk), .rst(rst), .bus(bus));

  int errors = 0;
  int checks = 0;

  // Reference: m[bank][col]; msel is the bank being drawn, the other one is displayed
  logic [8:0] m [2][512];
  int         msel;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic mdl_clear();
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < 512; i++) m[b][i] = '0;
    msel = 0;
  endtask

  task automatic draw(input int a, input logic [8:0] d);
    bus.buf_we = 1'b1; bus.buf_addr = 9'(a); bus.buf_data = d;
    tick();
    bus.buf_we = 1'b0;
    if (d[3:0] != 4'd0 && a <= 383) m[msel][a] = d;
  endtask

  task automatic swap();
    bus.hs = 1'b1; tick(); tick();
    bus.hs = 1'b0; tick();
    msel = 1 - msel;
  endtask

  task automatic scan(input int col, input logic fl, input string tag);
    logic [8:0] c, ra;
    int dsp;
    c   = 9'(col);
    ra  = fl ? {c[8], ~c[7:0]} : c;
    dsp = 1 - msel;
    bus.flip = fl; bus.hdump = c; bus.pxl_cen = 1'b1;
    tick();
    bus.pxl_cen = 1'b0;
    tick();
    chk($sformatf("%s col %0d", tag, col), 16'(bus.obj_pxl), 16'(m[dsp][ra]));
    m[dsp][ra] = '0;
  endtask

  task automatic scan_line(input logic fl, input string tag);
    for (int c = 0; c < 512; c++) scan(c, fl, tag);
  endtask

  // Waits out the clear while poking buf_we and hs, which must both be ignored
  task automatic wait_clear(input string tag);
    int n = 0;
    while (bus.clr_busy === 1'b1 && n < 600) begin
      bus.buf_we = 1'b1; bus.buf_addr = 9'd30; bus.buf_data = 9'h0A1;
      bus.hs = ((n % 16) >= 8);
      tick();
      n++;
    end
    bus.buf_we = 1'b0;
    bus.hs = 1'b0;
    chk(tag, 16'(n), 16'd512);
    mdl_clear();
  endtask

  initial begin
    rst = 1'b1;
    bus.pxl_cen = 0; bus.hs = 0; bus.flip = 0; bus.hdump = '0;
    bus.buf_we = 0; bus.buf_addr = '0; bus.buf_data = '0;
    tick(); tick();
    chk("reset obj_pxl", 16'(bus.obj_pxl), 16'h0);
    chk("reset clr_busy", 16'(bus.clr_busy), 16'h1);
    rst = 1'b0;
    wait_clear("initial clear length");
    tick();

    // Reset clear: bank A holds a pixel that the clear must wipe
    draw(5, 9'h1AB);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("clear busy after rst", 16'(bus.clr_busy), 16'h1);
    wait_clear("reset clear length");
    swap();
    scan(5, 1'b0, "cleared A");
    scan(30, 1'b0, "buf_we during clear");

    // Draw and display, full scan
    draw(100, 9'h0A7);
    swap();
    scan_line(1'b0, "draw100");

    // Transparency and HMAX bounds
    draw(50, 9'h0F0);
    draw(400, 9'h055);
    draw(383, 9'h1C3);
    draw(384, 9'h1C4);
    swap();
    scan_line(1'b0, "bounds");

    // Overwrite and erase-after-read
    draw(7, 9'h011);
    draw(7, 9'h022);
    swap();
    for (int c = 0; c < 16; c++) scan(c, 1'b0, "overwrite");
    swap();
    swap();
    for (int c = 0; c < 16; c++) scan(c, 1'b0, "erased");

    // Flip: column 1 reads address 0x0FE
    draw(9'h0FE, 9'h033);
    swap();
    scan(1, 1'b1, "flip");
    scan_line(1'b1, "flip line");

    // Swap timing: a draw on the swap cycle lands in the pre-swap bank
    bus.hs = 1'b1; tick();
    bus.buf_we = 1'b1; bus.buf_addr = 9'd61; bus.buf_data = 9'h1E1; tick();
    bus.buf_addr = 9'd62; bus.buf_data = 9'h1E2; tick();
    bus.buf_we = 1'b0; bus.hs = 1'b0; tick();
    m[msel][61] = 9'h1E1;
    msel = 1 - msel;
    m[msel][62] = 9'h1E2;
    scan(61, 1'b0, "swap edge old bank");
    scan(62, 1'b0, "swap edge new bank");
    swap();
    scan(62, 1'b0, "after swap");

    // Random lines
    for (int r = 0; r < 3; r++) begin
      logic fl;
      for (int k = 0; k < 40; k++) begin
        logic [8:0] d;
        d = 9'($urandom_range(0, 511));
        if ($urandom_range(0, 3) == 0) d[3:0] = 4'd0;
        draw(int'($urandom_range(0, 511)), d);
      end
      swap();
      fl = 1'($urandom_range(0, 1));
      scan_line(fl, $sformatf("rand%0d", r));
    end

    // Reset mid-line with sel=1 and a read in flight
    if (msel == 1) swap();
    draw(70, 9'h0B9);
    swap();
    bus.flip = 1'b0; bus.hdump = 9'd70; bus.pxl_cen = 1'b1; tick();
    bus.hdump = 9'd71; rst = 1'b1; tick();
    rst = 1'b0; bus.pxl_cen = 1'b0;
    chk("midline rst obj_pxl", 16'(bus.obj_pxl), 16'h0);
    chk("midline rst clr_busy", 16'(bus.clr_busy), 16'h1);
    wait_clear("midline clear length");
    tick();
    draw(20, 9'h0C5);
    scan(20, 1'b0, "sel reset display B");
    swap();
    scan(20, 1'b0, "sel reset display A");
    scan(30, 1'b0, "midline buf_we ignored");
    scan(70, 1'b0, "midline cleared");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
